// File: rtl/pe_seq_if.sv
// Bundles the layer-controller job port, the operand-buffer read port, the PE
// psum connections and the result handshake of the MAC sequencer.
interface pe_seq_if #(
   parameter int BW = 16,
   parameter int AW = 8
);
   logic                 iStart;
   logic [AW-1:0]        iLen;
   logic signed [BW-1:0] iBias;
   logic                 oBusy;
   logic                 oRdEn;
   logic [AW-1:0]        oAddr;
   logic signed [BW-1:0] iPeSum;
   logic signed [BW-1:0] oPeSum;
   logic signed [BW-1:0] oResult;
   logic                 oValid;
   logic                 iReady;

   modport master (
      input  iStart, iLen, iBias, iPeSum, iReady,
      output oBusy, oRdEn, oAddr, oPeSum, oResult, oValid
   );

   modport slave (
      output iStart, iLen, iBias, iPeSum, iReady,
      input  oBusy, oRdEn, oAddr, oPeSum, oResult, oValid
   );
endinterface

// File: rtl/pe_seq.sv
// Sequencer for one MAC processing element: walks the shared X/W buffer
// address, steers bias or the PE's own output back into the PE psum input,
// and hands the finished dot product out on a valid/ready port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for iStart; iLen/iBias latched on acceptance
// S_RUN   | issuing buffer reads, one address per cycle
// S_DRAIN | two cycles letting the buffer and PE pipelines empty
// S_DONE  | oResult valid, held until oValid & iReady
module pe_seq #(
   parameter int BW = 16,
   parameter int AW = 8
) (
   input  logic         iCLK,
   input  logic         iRSTn,
   pe_seq_if.master     bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [AW-1:0]        len_q, len_d;
   logic signed [BW-1:0] bias_q, bias_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic                 rd_en_q, rd_en_d;
   logic                 drain_q, drain_d;
   // rd_dly: an operand pair is sitting at the PE inputs this cycle
   logic                 rd_dly_q, rd_dly_d;
   // first: that pair is term 0, so the PE must see the bias, not its feedback
   logic                 first_q, first_d;
   logic signed [BW-1:0] result_q, result_d;

   // State register and all datapath flops; everything clears on reset.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         bias_q   <= '0;
         addr_q   <= '0;
         rd_en_q  <= 1'b0;
         drain_q  <= 1'b0;
         rd_dly_q <= 1'b0;
         first_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         bias_q   <= bias_d;
         addr_q   <= addr_d;
         rd_en_q  <= rd_en_d;
         drain_q  <= drain_d;
         rd_dly_q <= rd_dly_d;
         first_q  <= first_d;
         result_q <= result_d;
      end
   end

   // Next-state logic; the read enable is registered so the buffer sees it
   // one cycle after the decision, and the psum flags trail it by one more.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      bias_d   = bias_q;
      addr_d   = addr_q;
      rd_en_d  = rd_en_q;
      drain_d  = drain_q;
      result_d = result_q;
      rd_dly_d = rd_en_q;
      first_d  = rd_en_q & ~rd_dly_q;

      case (state_q)
         S_IDLE: begin
            if (bus.iStart) begin
               len_d  = bus.iLen;
               bias_d = bus.iBias;
               if (bus.iLen != '0) begin
                  state_d = S_RUN;
                  rd_en_d = 1'b1;
                  addr_d  = '0;
               end else begin
                  // Empty job: the dot product is just the bias.
                  state_d  = S_DONE;
                  result_d = bus.iBias;
               end
            end
         end
         S_RUN: begin
            if (addr_q == len_q - AW'(1)) begin
               state_d = S_DRAIN;
               rd_en_d = 1'b0;
               addr_d  = '0;
               drain_d = 1'b0;
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
         S_DRAIN: begin
            if (!drain_q) begin
               drain_d = 1'b1;
            end else begin
               // The last term's psum is on iPeSum this cycle.
               drain_d  = 1'b0;
               result_d = bus.iPeSum;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.iReady) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode; oPeSum depends only on registered flags and iPeSum.
   always_comb begin
      bus.oBusy   = (state_q != S_IDLE);
      bus.oValid  = (state_q == S_DONE);
      bus.oRdEn   = rd_en_q;
      bus.oAddr   = addr_q;
      bus.oResult = result_q;
      bus.oPeSum  = '0;
      if (rd_dly_q) begin
         bus.oPeSum = first_q ? bias_q : bus.iPeSum;
      end
   end

endmodule
